// File: rtl/mul_unit_pkg.sv
// Shared definitions for the execute-stage multiply unit and the ALU decoder.
package mul_unit_pkg;

   // ALUControl encodings produced by the ALU decoder
   localparam logic [3:0] ALU_ADD   = 4'b0000;
   localparam logic [3:0] ALU_SUB   = 4'b0001;
   localparam logic [3:0] ALU_AND   = 4'b0010;
   localparam logic [3:0] ALU_ORR   = 4'b0011;
   localparam logic [3:0] ALU_MUL   = 4'b0100;
   localparam logic [3:0] ALU_MOV   = 4'b0101;
   localparam logic [3:0] ALU_UMULL = 4'b0110;
   localparam logic [3:0] ALU_DIV   = 4'b0111;
   localparam logic [3:0] ALU_SMULL = 4'b1000;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIN  = 2'd2
   } mul_state_e;

   // True for the ALUControl codes this unit executes
   function automatic logic is_mul_op(input logic [3:0] op);
      return (op == ALU_MUL) || (op == ALU_UMULL) || (op == ALU_SMULL);
   endfunction

endpackage

// File: rtl/mul_shift_add_step.sv
// One iteration of the shift-add multiplier: conditional add into the upper
// accumulator half, then shift the {carry, acc} register right by one.
module mul_shift_add_step #(
   parameter int unsigned WIDTH = 32
) (
   input  logic                 i_carry,
   input  logic [2*WIDTH-1:0]   i_acc,
   input  logic [WIDTH-1:0]     i_mcand,
   output logic                 o_carry,
   output logic [2*WIDTH-1:0]   o_acc
);

   logic [WIDTH:0]   w_sum;
   logic [2*WIDTH:0] w_full;

   // Add multiplicand when the multiplier LSB is set, then shift right
   always_comb begin
      w_sum = {i_carry, i_acc[2*WIDTH-1:WIDTH]};
      if (i_acc[0]) begin
         w_sum = {i_carry, i_acc[2*WIDTH-1:WIDTH]} + {1'b0, i_mcand};
      end
      w_full  = {w_sum, i_acc[WIDTH-1:0]};
      o_carry = 1'b0;
      o_acc   = w_full[2*WIDTH:1];
   end

endmodule

// File: rtl/mul_unit.sv
// Iterative multicycle multiplier for MUL, UMULL and SMULL.
// SMULL runs on magnitudes and negates the final product when signs differ.
module mul_unit
   import mul_unit_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic             illegal,
   output logic [WIDTH-1:0] result_lo,
   output logic [WIDTH-1:0] result_hi,
   output logic             flag_n,
   output logic             flag_z
);

   localparam int unsigned PW = 2 * WIDTH;
   localparam int unsigned CW = $clog2(WIDTH + 1);

   mul_state_e       r_state, w_state_nxt;
   logic [CW-1:0]    r_cnt;
   logic [3:0]       r_op;
   logic [WIDTH-1:0] r_mcand;
   logic [PW-1:0]    r_acc;
   logic             r_carry;
   logic             r_neg;
   logic             r_ill_pend;
   logic             r_done, r_illegal, r_n, r_z;
   logic [WIDTH-1:0] r_lo, r_hi;

   logic             w_legal, w_accept;
   logic [WIDTH-1:0] w_abs_a, w_abs_b;
   logic             w_carry_nxt;
   logic [PW-1:0]    w_acc_nxt;
   logic [PW-1:0]    w_prod;
   logic [WIDTH-1:0] w_lo, w_hi;
   logic             w_n, w_z;

   assign w_legal  = is_mul_op(op);
   assign w_accept = (r_state == S_IDLE) && start && !flush;
   assign w_abs_a  = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
   assign w_abs_b  = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;

   mul_shift_add_step #(.WIDTH(WIDTH)) u_step (
      .i_carry (r_carry),
      .i_acc   (r_acc),
      .i_mcand (r_mcand),
      .o_carry (w_carry_nxt),
      .o_acc   (w_acc_nxt)
   );

   // Final product sign fix-up and result/flag formatting per operation
   always_comb begin
      w_prod = r_neg ? (~r_acc + PW'(1)) : r_acc;
      w_lo   = w_prod[WIDTH-1:0];
      w_hi   = w_prod[PW-1:WIDTH];
      w_n    = w_prod[PW-1];
      w_z    = (w_prod == '0);
      if (r_op == ALU_MUL) begin
         w_hi = '0;
         w_n  = w_prod[WIDTH-1];
         w_z  = (w_prod[WIDTH-1:0] == '0);
      end
   end

   // Next-state logic; flush wins over start and over FIN completion
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (w_accept) w_state_nxt = w_legal ? S_RUN : S_FIN;
         S_RUN: begin
            if (flush)                  w_state_nxt = S_IDLE;
            else if (r_cnt == CW'(1))   w_state_nxt = S_FIN;
         end
         S_FIN:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Operand capture, iteration datapath and registered results
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt      <= '0;
         r_op       <= '0;
         r_mcand    <= '0;
         r_acc      <= '0;
         r_carry    <= 1'b0;
         r_neg      <= 1'b0;
         r_ill_pend <= 1'b0;
         r_done     <= 1'b0;
         r_illegal  <= 1'b0;
         r_lo       <= '0;
         r_hi       <= '0;
         r_n        <= 1'b0;
         r_z        <= 1'b0;
      end else begin
         r_done    <= 1'b0;
         r_illegal <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_op    <= op;
                  r_carry <= 1'b0;
                  if (!w_legal) begin
                     r_mcand    <= '0;
                     r_acc      <= '0;
                     r_neg      <= 1'b0;
                     r_cnt      <= '0;
                     r_ill_pend <= 1'b1;
                  end else begin
                     r_ill_pend <= 1'b0;
                     r_cnt      <= CW'(WIDTH);
                     if (op == ALU_SMULL) begin
                        r_mcand <= w_abs_a;
                        r_acc   <= {{WIDTH{1'b0}}, w_abs_b};
                        r_neg   <= a[WIDTH-1] ^ b[WIDTH-1];
                     end else begin
                        r_mcand <= a;
                        r_acc   <= {{WIDTH{1'b0}}, b};
                        r_neg   <= 1'b0;
                     end
                  end
               end
            end
            S_RUN: begin
               if (!flush) begin
                  r_acc   <= w_acc_nxt;
                  r_carry <= w_carry_nxt;
                  r_cnt   <= r_cnt - CW'(1);
               end
            end
            S_FIN: begin
               if (!flush) begin
                  r_lo      <= w_lo;
                  r_hi      <= w_hi;
                  r_n       <= w_n;
                  r_z       <= w_z;
                  r_done    <= 1'b1;
                  r_illegal <= r_ill_pend;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy      = (r_state != S_IDLE);
   assign done      = r_done;
   assign illegal   = r_illegal;
   assign result_lo = r_lo;
   assign result_hi = r_hi;
   assign flag_n    = r_n;
   assign flag_z    = r_z;

endmodule

// File: tb/tb_mul_unit.sv
// Directed and random checks for mul_unit (WIDTH=32).
module tb_mul_unit;

   logic        clk = 1'b0;
   logic        reset, start, flush;
   logic [3:0]  op;
   logic [31:0] a, b;
   logic        busy, done, illegal, flag_n, flag_z;
   logic [31:0] result_lo, result_hi;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   int lat, bc, ndone, t0, tdone, sel;
   logic [3:0]  rop;
   logic [31:0] ra, rb;
   logic signed [63:0] sa, sb;
   logic [63:0] eprod;
   logic [31:0] elo, ehi;
   logic        en, ez, eill;

   mul_unit #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .flush(flush), .busy(busy), .done(done), .illegal(illegal),
      .result_lo(result_lo), .result_hi(result_hi),
      .flag_n(flag_n), .flag_z(flag_z)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issue one operation and wait (bounded) for done; lat counts edges after acceptance
   task automatic run_op(input logic [3:0] t_op, input logic [31:0] ta, input logic [31:0] tb_v,
                         output int t_lat, output int t_bc);
      @(negedge clk); op = t_op; a = ta; b = tb_v; start = 1'b1;
      @(negedge clk); start = 1'b0;
      t_lat = 0;
      t_bc  = (busy === 1'b1) ? 1 : 0;
      while (done !== 1'b1 && t_lat < 60) begin
         @(negedge clk);
         t_lat++;
         if (busy === 1'b1) t_bc++;
      end
   endtask

   function automatic logic [31:0] pick(input int s);
      case (s)
         0: return 32'h0000_0000;
         1: return 32'h0000_0001;
         2: return 32'h8000_0000;
         3: return 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      reset = 1'b0; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
      repeat (3) @(negedge clk);
      chk("reset_outs", {busy, done, illegal, flag_n, flag_z, result_hi, result_lo}, '0);
      reset = 1'b1;

      // UMULL max x max
      run_op(4'b0110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc);
      chk("umull_lat", lat, 33);
      chk("umull_busy_cycles", bc, 33);
      chk("umull_prod", {result_hi, result_lo}, 64'hFFFF_FFFE_0000_0001);
      chk("umull_flags", {done, illegal, flag_n, flag_z}, 4'b1010);
      @(negedge clk);
      chk("done_one_cycle", {done, busy}, 2'b00);

      // SMULL cases
      run_op(4'b1000, 32'hFFFF_FFFE, 32'h0000_0003, lat, bc);
      chk("smull_m2x3", {result_hi, result_lo, flag_n, flag_z}, {64'hFFFF_FFFF_FFFF_FFFA, 2'b10});
      run_op(4'b1000, 32'h8000_0000, 32'h8000_0000, lat, bc);
      chk("smull_min_sq", {result_hi, result_lo, flag_n, flag_z}, {64'h4000_0000_0000_0000, 2'b00});
      run_op(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc);
      chk("smull_m1xm1", {result_hi, result_lo, flag_n, flag_z}, {64'h0000_0000_0000_0001, 2'b00});

      // MUL low-word forms
      run_op(4'b0100, 32'h0001_0000, 32'h0001_0000, lat, bc);
      chk("mul_zero_lo", {result_hi, result_lo, flag_n, flag_z}, {64'h0, 2'b01});
      run_op(4'b0100, 32'h7FFF_FFFF, 32'h0000_0002, lat, bc);
      chk("mul_neg", {result_hi, result_lo, flag_n, flag_z}, {64'h0000_0000_FFFF_FFFE, 2'b10});

      // Illegal op
      run_op(4'b0000, 32'h1234_5678, 32'h9ABC_DEF0, lat, bc);
      chk("illegal_lat", lat, 1);
      chk("illegal_out", {done, illegal, result_hi, result_lo, flag_n, flag_z}, {2'b11, 64'h0, 2'b01});
      @(negedge clk);
      chk("illegal_clear", {done, illegal}, 2'b00);

      // start held for 40 cycles: one completion, then a back-to-back accept
      @(negedge clk); op = 4'b0110; a = 32'd3; b = 32'd5; start = 1'b1;
      ndone = 0; t0 = 0; tdone = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (i == 0) t0 = cyc;
         if (done === 1'b1) begin ndone++; tdone = cyc; end
      end
      start = 1'b0;
      chk("held_one_done", ndone, 1);
      chk("held_first_edge", tdone - t0, 33);
      chk("held_second_busy", busy, 1'b1);
      lat = 0;
      while (done !== 1'b1 && lat < 60) begin @(negedge clk); lat++; end
      chk("held_second_edge", cyc - t0, 67);
      chk("held_second_prod", {result_hi, result_lo}, 64'd15);

      // Known results to verify hold across aborts
      run_op(4'b0100, 32'h7FFF_FFFF, 32'h0000_0002, lat, bc);

      // flush at RUN cycle 10
      @(negedge clk); op = 4'b0110; a = 32'd3; b = 32'd4; start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk); flush = 1'b0;
      chk("flush_run_busy", busy, 1'b0);
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done === 1'b1) ndone++;
      end
      chk("flush_run_nodone", ndone, 0);
      chk("flush_run_hold", {result_hi, result_lo, flag_n, flag_z}, {64'h0000_0000_FFFF_FFFE, 2'b10});

      // flush in FIN cycle beats completion
      @(negedge clk); op = 4'b0110; a = 32'd3; b = 32'd4; start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (32) @(negedge clk);
      flush = 1'b1;
      @(negedge clk); flush = 1'b0;
      chk("flush_fin", {done, busy, result_hi, result_lo}, {2'b00, 64'h0000_0000_FFFF_FFFE});

      // flush with start in IDLE: nothing accepted
      @(negedge clk); op = 4'b0110; a = 32'd3; b = 32'd4; start = 1'b1; flush = 1'b1;
      @(negedge clk); start = 1'b0; flush = 1'b0;
      chk("flush_idle_start", {busy, done}, 2'b00);

      // Asynchronous reset in RUN cycle 5
      @(negedge clk); op = 4'b0110; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (4) @(negedge clk);
      chk("pre_reset_busy", busy, 1'b1);
      reset = 1'b0;
      #1;
      chk("async_reset", {busy, done, illegal, flag_n, flag_z, result_hi, result_lo}, '0);
      @(negedge clk); reset = 1'b1;
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) ndone++;
      end
      chk("post_reset_idle", ndone, 0);

      // Random regression
      for (int n = 0; n < 1000; n++) begin
         sel = $urandom_range(0, 3);
         case (sel)
            0: rop = 4'b0100;
            1: rop = 4'b0110;
            2: rop = 4'b1000;
            default: rop = 4'($urandom_range(0, 15));
         endcase
         ra = pick($urandom_range(0, 7));
         rb = pick($urandom_range(0, 7));
         sa = {{32{ra[31]}}, ra};
         sb = {{32{rb[31]}}, rb};
         eill = 1'b0;
         case (rop)
            4'b0100: begin
               eprod = {32'h0, ra} * {32'h0, rb};
               elo = eprod[31:0]; ehi = '0; en = eprod[31]; ez = (eprod[31:0] == 32'h0);
            end
            4'b0110: begin
               eprod = {32'h0, ra} * {32'h0, rb};
               elo = eprod[31:0]; ehi = eprod[63:32]; en = eprod[63]; ez = (eprod == 64'h0);
            end
            4'b1000: begin
               eprod = sa * sb;
               elo = eprod[31:0]; ehi = eprod[63:32]; en = eprod[63]; ez = (eprod == 64'h0);
            end
            default: begin
               elo = '0; ehi = '0; en = 1'b0; ez = 1'b1; eill = 1'b1;
            end
         endcase
         run_op(rop, ra, rb, lat, bc);
         chk("rand_lat", lat, eill ? 1 : 33);
         chk("rand_result", {illegal, flag_n, flag_z, result_hi, result_lo}, {eill, en, ez, ehi, elo});
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mul_unit.md
Name: mul_unit

Overview:
- Iterative multicycle multiplier that executes the multiply operations chosen by the instruction decoder's ALU decoder.
- Recognised ALUControl codes: MUL 4'b0100, UMULL 4'b0110, SMULL 4'b1000.
- The main FSM holds the execute step on a start/busy/done handshake while this unit works.
- Results go to ResultSrc-selected write-back: lo word to Rd, hi word to RdHi for long forms.

Parameters:
- WIDTH, 32: operand width in bits. Product is 2*WIDTH bits; iteration count is WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; unit resets while reset==0.
- start  in  1  request strobe; accepted only in IDLE.
- op  in  4  ALUControl code, sampled with start.
- a  in  WIDTH  Rn operand, sampled with start.
- b  in  WIDTH  Rm operand, sampled with start.
- flush  in  1  synchronous abort of an in-flight operation.
- busy  out  1  high in RUN and FIN.
- done  out  1  one-cycle pulse, results valid.
- illegal  out  1  high with done when op was unsupported.
- result_lo  out  WIDTH  low product word.
- result_hi  out  WIDTH  high product word; 0 for MUL.
- flag_n  out  1  sign of result.
- flag_z  out  1  result is zero.

Behaviour:
- Reset (reset==0, async): state=IDLE, counter=0, all outputs 0, internal accumulators cleared.
- States: IDLE, RUN, FIN.
- IDLE:
  - start=1 with a legal op: latch op, a and b. For SMULL, latch |a|, |b| and neg = a[W-1]^b[W-1]. Load counter=WIDTH, then go to RUN.
  - start=1 with an illegal op: go to FIN with illegal pending and the product forced to 0.
- RUN, one shift-add step per cycle:
  - If multiplier LSB=1, add multiplicand to the upper accumulator half, with carry into bit 2W.
  - Shift the {carry, acc} register right by 1.
  - Decrement counter; when counter reaches 1 in this cycle, next state is FIN.
- FIN:
  - Apply two's-complement negation of the 2W-bit product if neg.
  - Register result_lo/result_hi and the flags.
  - done=1 for exactly this cycle; illegal=1 if pending.
  - Next state is IDLE.
- Latency: a start accepted at edge k gives done=1 in the cycle after edge k+WIDTH+1 (33 edges for WIDTH=32). An illegal op gives done after edge k+1.
- Width rules:
  - UMULL: unsigned 2W-bit product.
  - SMULL: signed 2W-bit product. |0x80000000| is 0x80000000 treated as unsigned; the result must still be exact.
  - MUL: low W bits only; result_hi=0.
- Flags:
  - flag_n = bit 2W-1 for long forms, bit W-1 for MUL.
  - flag_z = 1 iff all meaningful result bits are 0.
- Output hold: result_lo, result_hi and flags hold their values until the next FIN. Between operations, done and illegal are 0.
- start while busy: ignored, not queued. No effect on the in-flight operation.
- flush=1 in RUN or FIN: next state is IDLE, no done pulse, outputs unchanged. flush takes priority over FIN completion. flush in IDLE has no effect, and flush overrides a simultaneous start.
- reset asserted mid-operation: immediate return to the reset values; no done.
- Back-to-back: start may be asserted in the IDLE cycle right after FIN; there is no idle gap requirement.

Decomposition:
- Shared package holds:
  - ALUControl localparams: ALU_ADD 4'b0000, ALU_SUB 4'b0001, ALU_AND 4'b0010, ALU_ORR 4'b0011, ALU_MUL 4'b0100, ALU_MOV 4'b0101, ALU_UMULL 4'b0110, ALU_DIV 4'b0111, ALU_SMULL 4'b1000.
  - State encoding: IDLE, RUN, FIN.
- The decoder and this unit both include the package.
- One natural sub-module, mul_shift_add_step: a combinational single iteration that takes {carry, acc, multiplicand} and returns the next {carry, acc}. It is instantiated once inside mul_unit.

Test Plan:
- UMULL: a=0xFFFFFFFF, b=0xFFFFFFFF, start at edge 0. Response: busy=1 for edges 1..33; done=1 for one cycle after edge 33; hi=0xFFFFFFFE, lo=0x00000001, N=1, Z=0.
- SMULL cases:
  - -2 × 3 gives hi=0xFFFFFFFF, lo=0xFFFFFFFA, N=1.
  - 0x80000000 × 0x80000000 gives hi=0x40000000, lo=0, N=0.
  - -1 × -1 gives hi=0, lo=1.
- MUL: 0x00010000 × 0x00010000 gives lo=0, hi=0, Z=1, N=0. Then 0x7FFFFFFF × 2 gives lo=0xFFFFFFFE, hi=0, N=1.
- Handshake:
  - start held high for 40 cycles: exactly one operation completes, then a second is accepted in the IDLE cycle after FIN.
  - op=4'b0000: done and illegal pulse after edge 1, results 0.
- Abort:
  - flush at RUN cycle 10: no done, busy drops next cycle, prior results retained.
  - reset pulled low at RUN cycle 5: all outputs 0 asynchronously, state IDLE.
- Random regression: 1000 random a, b and op values checked against a 64-bit reference product, including operands 0, 1 and 0x80000000.
